// File: rtl/jt12_mix_acc.sv
// jt12_mix_acc: time-multiplexed per-channel operator accumulator and stereo mixer.
// Optional JT12_MIX_LADDER_EN adds the DAC ladder offset to each completed channel.
module jt12_mix_acc #(
  parameter int CH   = 6,
  parameter int WIN  = 9,
  parameter int WACC = 9,
  parameter int WOUT = 16,
  parameter int SAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic                   zero,
  input  logic signed [WIN-1:0]  op_result,
  input  logic [2:0]             alg,
  input  logic [1:0]             rl,
  input  logic [CH-1:0]          ch_mask,
  input  logic                   pcm_en,
  input  logic signed [WIN-1:0]  pcm,
  output logic signed [WOUT-1:0] left,
  output logic signed [WOUT-1:0] right,
  output logic                   sample_valid
);
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(CH - 1);
  function automatic logic signed [WACC-1:0] add_acc(input logic signed [WACC-1:0] a, input logic signed [WACC-1:0] b);
    logic [WACC:0] t;
    t = {a[WACC-1], a} + {b[WACC-1], b};
    return (SAT != 0 && t[WACC] != t[WACC-1]) ? (t[WACC] ? {1'b1, {(WACC-1){1'b0}}} : {1'b0, {(WACC-1){1'b1}}}) : t[WACC-1:0];
  endfunction
  function automatic logic signed [WOUT-1:0] add_out(input logic signed [WOUT-1:0] a, input logic signed [WOUT-1:0] b);
    logic [WOUT:0] t;
    t = {a[WOUT-1], a} + {b[WOUT-1], b};
    return (SAT != 0 && t[WOUT] != t[WOUT-1]) ? (t[WOUT] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}}) : t[WOUT-1:0];
  endfunction
  logic [1:0] grp_q, grp;
  logic [CW-1:0] ch_q, ch;
  logic done_q, done, armed, active, en;
  logic signed [WACC-1:0] sum [CH];
  logic signed [WACC-1:0] op_x, sum_nx;
  logic signed [WOUT-1:0] mix_l, mix_r, base_l, base_r, cv, term_l, term_r;
`ifdef JT12_MIX_LADDER_EN
  logic signed [WOUT-1:0] off_l, off_r;
`endif
  // done marks slots past the end of the frame; they are ignored until the next zero
  always_comb begin
    grp = zero ? 2'd0 : done_q ? grp_q : ch_q == LAST ? grp_q + 2'd1 : grp_q;
    ch = zero ? '0 : done_q ? ch_q : ch_q == LAST ? '0 : ch_q + CW'(1);
    done = !zero && (done_q || (ch_q == LAST && grp_q == 2'd3));
    active = (zero || armed) && !done;
    en = alg == 3'd7 || grp == 2'd3 || (grp != 2'd0 && alg >= 3'd5) || (alg == 3'd4 && grp == 2'd2);
    op_x = WACC'(op_result);
    sum_nx = grp == 2'd0 ? (en ? op_x : '0) : (en ? add_acc(sum[ch], op_x) : sum[ch]);
    cv = !ch_mask[ch] ? '0 : (ch == LAST && pcm_en) ? WOUT'(pcm) : WOUT'(sum_nx);
`ifdef JT12_MIX_LADDER_EN
    off_l = !ch_mask[ch] ? '0 : !cv[WOUT-1] ? WOUT'(7) : rl[1] ? '0 : WOUT'(-6);
    off_r = !ch_mask[ch] ? '0 : !cv[WOUT-1] ? WOUT'(7) : rl[0] ? '0 : WOUT'(-6);
    term_l = (rl[1] ? cv : '0) + off_l;
    term_r = (rl[0] ? cv : '0) + off_r;
`else
    term_l = rl[1] ? cv : '0;
    term_r = rl[0] ? cv : '0;
`endif
    base_l = zero ? '0 : mix_l;
    base_r = zero ? '0 : mix_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q <= '0;
      ch_q <= '0;
      done_q <= 1'b0;
      armed <= 1'b0;
      mix_l <= '0;
      mix_r <= '0;
      left <= '0;
      right <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < CH; i++) sum[i] <= '0;
    end else begin
      sample_valid <= clk_en && zero && armed;
      if (clk_en) begin
        if (zero || armed) begin
          grp_q <= grp;
          ch_q <= ch;
          done_q <= done;
        end
        if (zero) armed <= 1'b1;
        if (zero && armed) begin
          left <= mix_l;
          right <= mix_r;
        end
        if (active) sum[ch] <= sum_nx;
        mix_l <= (active && grp == 2'd3) ? add_out(base_l, term_l) : base_l;
        mix_r <= (active && grp == 2'd3) ? add_out(base_r, term_r) : base_r;
      end
    end
  end
endmodule

// File: tb/tb_jt12_mix_acc.sv
// tb_jt12_mix_acc: directed frames against a saturating and a wrapping instance.
module tb_jt12_mix_acc;
  localparam int CH = 6, WIN = 9, WACC = 9, WOUT = 16;
`ifdef JT12_MIX_LADDER_EN
  localparam int LAD = 1;
`else
  localparam int LAD = 0;
`endif
  logic clk = 0, rst = 1, clk_en = 0, zero = 0, pcm_en = 0;
  logic signed [WIN-1:0] op_result = '0, pcm = '0;
  logic [2:0] alg = '0;
  logic [1:0] rl = '0;
  logic [CH-1:0] ch_mask = '1;
  logic signed [WOUT-1:0] left_s, right_s, left_w, right_w;
  logic sv_s, sv_w;
  typedef struct {string name; int l; int r; int lw; int rw;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int checks = 0, errors = 0;
  int op_tab[4][CH];
  logic [2:0] alg_tab[CH];
  logic [1:0] rl_tab[CH];
  int gap_at = -1;
  jt12_mix_acc #(.CH(CH), .WIN(WIN), .WACC(WACC), .WOUT(WOUT), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero), .op_result(op_result), .alg(alg), .rl(rl),
    .ch_mask(ch_mask), .pcm_en(pcm_en), .pcm(pcm), .left(left_s), .right(right_s), .sample_valid(sv_s));
  jt12_mix_acc #(.CH(CH), .WIN(WIN), .WACC(WACC), .WOUT(WOUT), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero), .op_result(op_result), .alg(alg), .rl(rl),
    .ch_mask(ch_mask), .pcm_en(pcm_en), .pcm(pcm), .left(left_w), .right(right_w), .sample_valid(sv_w));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sv_s || sv_w) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: sat L=%0d R=%0d wrap L=%0d R=%0d", left_s, right_s, left_w, right_w);
      end else begin
        e_m = q.pop_front();
        if (sv_s !== sv_w || left_s !== WOUT'(e_m.l) || right_s !== WOUT'(e_m.r) || left_w !== WOUT'(e_m.lw) || right_w !== WOUT'(e_m.rw)) begin
          errors++;
          $display("FAIL %s: got sat L=%0d R=%0d wrap L=%0d R=%0d (pulse %b/%b), want sat L=%0d R=%0d wrap L=%0d R=%0d",
                   e_m.name, left_s, right_s, left_w, right_w, sv_s, sv_w, e_m.l, e_m.r, e_m.lw, e_m.rw);
        end
      end
    end
  end
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", n, got, want);
    end
  endtask
  task automatic setup(input int op, input logic [2:0] a, input logic [1:0] r, input logic [CH-1:0] m);
    for (int g = 0; g < 4; g++) for (int c = 0; c < CH; c++) op_tab[g][c] = op;
    for (int c = 0; c < CH; c++) begin
      alg_tab[c] = a;
      rl_tab[c] = r;
    end
    ch_mask = m;
    pcm_en = 0;
    gap_at = -1;
  endtask
  task automatic slot(input int s);
    int g, c;
    g = s >= 4 * CH ? 3 : s / CH;
    c = s >= 4 * CH ? CH - 1 : s % CH;
    clk_en = 1;
    zero = s == 0;
    op_result = WIN'(op_tab[g][c]);
    alg = alg_tab[c];
    rl = rl_tab[c];
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    clk_en = 0;
    zero = 1;
    op_result = WIN'(99);
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input int n);
    for (int s = 0; s < n; s++) begin
      if (s == gap_at) begin
        idle();
        idle();
      end
      slot(s);
    end
  endtask
  task automatic expect_frame(input string n, input int l, input int r, input int lw, input int rw);
    q.push_back('{name: n, l: l, r: r, lw: lw, rw: rw});
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_left", int'(left_s), 0);
    chk("reset_right", int'(right_s), 0);
    chk("reset_valid", int'(sv_s), 0);
    chk("reset_left_wrap", int'(left_w), 0);
    setup(1, 3'd7, 2'b11, '1);
    frame(27);
    expect_frame("all_alg7", 24 + 42 * LAD, 24 + 42 * LAD, 24 + 42 * LAD, 24 + 42 * LAD);
    setup(0, 3'd7, 2'b11, 6'b000001);
    for (int g = 0; g < 3; g++) op_tab[g][0] = 100;
    op_tab[3][0] = 5;
    alg_tab[0] = 3'd0;
    gap_at = 4;
    frame(24);
    expect_frame("alg0_s4_only", 5 + 7 * LAD, 5 + 7 * LAD, 5 + 7 * LAD, 5 + 7 * LAD);
    setup(200, 3'd7, 2'b11, 6'b000100);
    frame(24);
    expect_frame("clamp_wrap", 255 + 7 * LAD, 255 + 7 * LAD, -224, -224);
    setup(77, 3'd7, 2'b10, 6'b100000);
    pcm_en = 1;
    pcm = -9'sd50;
    frame(24);
    expect_frame("pcm_left", -50, -6 * LAD, -50, -6 * LAD);
    setup(0, 3'd0, 2'b10, 6'b000010);
    op_tab[3][1] = -3;
    frame(24);
    expect_frame("neg_left_only", -3, -6 * LAD, -3, -6 * LAD);
    setup(0, 3'd0, 2'b11, 6'b000010);
    op_tab[3][1] = 4;
    frame(24);
    expect_frame("pos_both", 4 + 7 * LAD, 4 + 7 * LAD, 4 + 7 * LAD, 4 + 7 * LAD);
    setup(1, 3'd7, 2'b11, '1);
    frame(10);
    expect_frame("short10", 0, 0, 0, 0);
    frame(21);
    expect_frame("short21", 12 + 21 * LAD, 12 + 21 * LAD, 12 + 21 * LAD, 12 + 21 * LAD);
    setup(1, 3'd0, 2'b11, 6'b011000);
    alg_tab[3] = 3'd4;
    rl_tab[3] = 2'b10;
    alg_tab[4] = 3'd5;
    rl_tab[4] = 2'b01;
    frame(24);
    expect_frame("alg4_alg5", 2 + 14 * LAD, 3 + 14 * LAD, 2 + 14 * LAD, 3 + 14 * LAD);
    setup(1, 3'd7, 2'b11, '1);
    frame(5);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midreset_left", int'(left_s), 0);
    chk("midreset_right", int'(right_s), 0);
    chk("midreset_valid", int'(sv_s), 0);
    chk("midreset_right_wrap", int'(right_w), 0);
    frame(24);
    expect_frame("after_reset", 24 + 42 * LAD, 24 + 42 * LAD, 24 + 42 * LAD, 24 + 42 * LAD);
    slot(0);
    clk_en = 0;
    zero = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt12_mix_acc.md
Name: jt12_mix_acc

Overview:
- Parametrised successor to the single-channel FM accumulator: one time-multiplexed block accumulates operator outputs for CH channels and produces a mixed stereo sample per frame.
- Holds per-channel partial sums across the operator-major slot order (S1, S3, S2, S4 groups), applies algorithm-dependent summing, PCM substitution, per-channel mute and panning, and saturating or wrapping arithmetic.
- Sits after the operator pipeline and feeds the audio output stage directly.

Parameters:
- CH, 6, number of channels; frame length is 4*CH slots.
- WIN, 9, signed width of op_result and pcm.
- WACC, 9, signed width of each per-channel sum.
- WOUT, 16, signed width of left/right and the mix accumulators.
- SAT, 1, 1 = clamp on overflow at every adder; 0 = two's-complement wrap.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  slot strobe; all state advances only when high.
- zero  in  1  marks slot 0 of a frame; sampled with clk_en.
- op_result  in  WIN  signed operator output for the current slot.
- alg  in  3  algorithm of the current slot's channel.
- rl  in  2  panning of the current slot's channel, as {left, right}.
- ch_mask  in  CH  per-channel enable; 1 = audible.
- pcm_en  in  1  replaces channel CH-1 with PCM.
- pcm  in  WIN  signed PCM sample.
- left  out  WOUT  signed mixed left sample.
- right  out  WOUT  signed mixed right sample.
- sample_valid  out  1  one-clk pulse when left/right update.

Behaviour:
- Reset: one clk with rst=1 clears the following, regardless of clk_en:
  - slot counter, all channel sums and both mix accumulators;
  - left, right and sample_valid set to 0;
  - armed cleared.
- Arming: slots are ignored until the first clk_en cycle with zero=1, which sets armed.
- Slot index:
  - zero=1 forces the slot index to 0; otherwise the index increments per clk_en.
  - The index saturates at 4*CH-1; extra slots are ignored until the next zero.
  - Decode: grp = s / CH (0..3 = S1, S3, S2, S4); ch = s % CH.
- Summing enable per algorithm:
  - alg 0-3: S4 only.
  - alg 4: S2 and S4.
  - alg 5, 6: every group except S1.
  - alg 7: all groups.
- Channel sum:
  - grp 0 loads the channel sum with op_result if enabled, else 0.
  - Later groups add op_result if enabled.
  - The sum is sign-extended to WACC; SAT controls clamp vs wrap.
- Channel completion: at grp 3, the completed value cv is the sum including the current slot.
  - If ch=CH-1 and pcm_en=1, cv = pcm instead.
  - If ch_mask[ch]=0, cv = 0.
  - cv (sign-extended to WOUT) is added to the left mix if rl[1]=1 and to the right mix if rl[0]=1, with SAT rule at WOUT.
- Frame end: on a clk_en cycle with zero=1 and armed=1:
  - left/right take the mix totals of the previous frame and sample_valid pulses for that clk.
  - Mixes are cleared, then slot 0 of the new frame is processed normally in the same cycle.
- Boundary cases:
  - A short frame (zero before slot 4*CH-1) outputs the partial mix; channels whose S4 slot did not arrive contribute nothing.
  - The first zero after reset sets armed but gives no sample_valid.
  - rst asserted mid-frame discards everything.
- Latency: a sample appears on the clk_en cycle that starts the following frame.
- clk_en=0: all state holds and sample_valid=0.

Optional Feature:
- JT12_MIX_LADDER_EN defined: each completed channel adds a DAC ladder offset to each side before mixing.
  - +7 if cv>=0.
  - If cv<0: 0 when the side is panned, -6 when it is not.
  - An unpanned side receives the offset alone.
  - Masked channels (ch_mask=0) get no offset.
- Not defined: no offset; unpanned sides receive nothing.

Test Plan:
- Reset then a full frame with all channels alg=7, op_result=1, rl=2'b11, mask all-ones, SAT=1, macro off -> second zero gives left=right=24 (4 operators × 6 channels), sample_valid high for 1 clk.
- Channel 0 alg=0, S1..S3 = 100 and S4 = 5, other channels masked -> left=right=5.
- Channel 2 alg=7, four slots of 200 with WACC=9 and SAT=1 -> channel sum clamps to 255; with SAT=0 it wraps to 800 mod 512 = 288, i.e. -224 signed.
- pcm_en=1, pcm=-50, channel 5 rl=2'b10, op_result=77 -> left=-50, right=0.
- Zero asserted after 10 slots -> output holds only the channels that completed; counter restarts at 0; rst mid-frame -> outputs 0 and no pulse at the next zero.
- Macro on, one channel cv=-3, rl=2'b10, others masked -> left=-3, right=-6; cv=4, rl=2'b11 -> left=right=11.
